// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - elastic WIDTH x DEPTH register pipeline with valid/ready flow control
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears valid and data)
//   flush      synchronous clear of all stage valids, refuses input that cycle
//   in_valid   producer presents in_data
//   in_ready   pipe accepts a word this cycle
//   in_data    producer word
//   out_valid  last stage holds a word
//   out_ready  consumer accepts out_data this cycle
//   out_data   last-stage word
//   occ        words held (only when DFF_PIPE_OCC_EN is defined)
//
// Optional feature macro: DFF_PIPE_OCC_EN
module dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef DFF_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  logic [DEPTH-1:0] r;
  logic [DEPTH-1:0] uv;
  logic [WIDTH-1:0] ud [DEPTH];

  // A stage may load when it is empty or anything downstream of it can move;
  // the accumulator avoids a self-referencing vector in the ready chain.
  always_comb begin
    logic acc;
    acc = out_ready;
    r   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc  = acc | ~v[k];
      r[k] = acc;
    end
  end

  // Upstream valid/data seen by each stage; stage 0 is fed by the producer.
  always_comb begin
    uv[0] = in_valid & ~flush;
    ud[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      uv[k] = v[k-1];
      ud[k] = d[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (r[k]) begin
          v[k] <= uv[k];
          if (uv[k]) begin
            d[k] <= ud[k];
          end
        end
      end
      // Flush drops every held word; data registers are left as they are.
      if (flush) begin
        v <= '0;
      end
    end
  end

  assign in_ready  = r[0] & ~flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

`ifdef DFF_PIPE_OCC_EN
  localparam int OCCW = $clog2(DEPTH + 1);

  logic            in_hs;
  logic            out_hs;
  logic [OCCW-1:0] occ_q;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else if (in_hs && !out_hs) begin
      occ_q <= occ_q + OCCW'(1);
    end else if (out_hs && !in_hs) begin
      occ_q <= occ_q - OCCW'(1);
    end
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// tb/tb_dff_pipe.sv - directed self-checking bench for dff_pipe (WIDTH=8, DEPTH=4)
module tb_dff_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef DFF_PIPE_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] occ;
`endif

  int n_checks;
  int n_fail;

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DFF_PIPE_OCC_EN
    ,
    .occ       (occ)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_occ(input string tag, input int exp);
`ifdef DFF_PIPE_OCC_EN
    check(tag, 32'(occ), 32'(exp));
`else
    if (exp < 0) $display("occ not built for %s", tag);
`endif
  endtask

  // From one falling edge, through the rising edge, to the next falling edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int acc;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check_occ("rst_occ", 0);
    rst = 1'b0;
    tick();

    // Single word latency: accepted on edge N, visible after edge N+3
    in_valid = 1'b1;
    in_data  = 8'hA5;
    #1 check("lat_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_occ("lat_occ_1", 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("lat_valid_%0d", i), 32'(out_valid), (i == 3) ? 32'd1 : 32'd0);
      if (i == 3) check("lat_data", 32'(out_data), 32'hA5);
      tick();
    end
    check_occ("lat_occ_0", 0);

    // Streaming 0x00..0x0F back to back
    for (int c = 0; c <= 20; c++) begin
      check($sformatf("str_valid_%0d", c), 32'(out_valid), (c >= 4 && c < 20) ? 32'd1 : 32'd0);
      if (c >= 4 && c < 20) check($sformatf("str_data_%0d", c), 32'(out_data), 32'(c - 4));
      in_valid = (c < 16);
      in_data  = 8'(c);
      #1 if (c < 16) check($sformatf("str_ready_%0d", c), 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;

    // Fill with the output stalled
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + acc);
      #1 if (in_ready) acc++;
      tick();
    end
    check("fill_accepted", 32'(acc), 32'd4);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_out_valid", 32'(out_valid), 32'd1);
    check("fill_out_data", 32'(out_data), 32'h10);
    check_occ("fill_occ", 4);

    // Full pipe passes a word straight through when both sides handshake
    in_data   = 8'h14;
    out_ready = 1'b1;
    #1 check("pass_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_occ("pass_occ", 4);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("drain_data_%0d", i), 32'(out_data), 32'(8'h10 + i));
      tick();
    end
    check("drain_empty", 32'(out_valid), 32'd0);
    check_occ("drain_occ", 0);

    // Bubble collapse behind a stalled word
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1;
    in_data  = 8'h02;
    tick();
    in_valid = 1'b0;
    tick();
    check("bub_stall_data_a", 32'(out_data), 32'h01);
    tick();
    check("bub_stall_valid", 32'(out_valid), 32'd1);
    check("bub_stall_data_b", 32'(out_data), 32'h01);
    check_occ("bub_occ", 2);
    out_ready = 1'b1;
    tick();
    check("bub_second_valid", 32'(out_valid), 32'd1);
    check("bub_second_data", 32'(out_data), 32'h02);
    tick();
    check("bub_done", 32'(out_valid), 32'd0);

    // Flush with three words held and a word offered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h21 + i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("fl_pre_valid", 32'(out_valid), 32'd1);
    check_occ("fl_pre_occ", 3);
    in_valid = 1'b1;
    in_data  = 8'h99;
    flush    = 1'b1;
    #1 check("fl_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check_occ("fl_occ", 0);
    out_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) acc++;
      tick();
    end
    check("fl_nothing_left", 32'(acc), 32'd0);

    // Refill, then asynchronous reset between edges
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h31;
    tick();
    in_data = 8'h32;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1 check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_out_data", 32'(out_data), 32'd0);
    check_occ("ar_occ", 0);
    #1 rst = 1'b0;
    check("ar_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("ar_after_edge", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
